// File: rtl/exe_mem_reg.sv
// exe_mem_reg: EXE/MEM pipeline register that merges exceptions and suppresses their side effects.
// The optional alignment check is built only when MEM_ADDR_ALIGN_CHECK_EN is defined.
module exe_mem_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXE_Stall,
    input  logic        EXE_Flush,
    input  logic        EXE_Valid,
    input  logic [31:0] EXE_PC,
    input  logic [31:0] EXE_ALUOut,
    input  logic        Overflow_valid,
    input  logic        EXE_ExcValid,
    input  logic [4:0]  EXE_ExcCode,
    input  logic [2:0]  EXE_MemOp,
    input  logic        EXE_RegWr,
    input  logic [4:0]  EXE_Dst,
    input  logic [31:0] EXE_StoreData,
    output logic        MEM_Valid,
    output logic [31:0] MEM_PC,
    output logic [31:0] MEM_ALUOut,
    output logic [2:0]  MEM_MemOp,
    output logic        MEM_RegWr,
    output logic [4:0]  MEM_Dst,
    output logic [31:0] MEM_StoreData,
    output logic        MEM_ExcValid,
    output logic [4:0]  MEM_ExcCode,
    output logic [31:0] MEM_BadVAddr
);
    logic [2:0]  w_op;
    logic        w_adel;
    logic        w_ades;
    logic        w_exc;
    logic [4:0]  w_code;
    logic [31:0] w_badva;

    assign w_op = (EXE_MemOp == 3'd7) ? 3'd0 : EXE_MemOp;
`ifdef MEM_ADDR_ALIGN_CHECK_EN
    logic w_mis_h;
    logic w_mis_w;
    assign w_mis_h = EXE_ALUOut[0];
    assign w_mis_w = |EXE_ALUOut[1:0];
    assign w_adel  = (w_op == 3'd2 && w_mis_h) || (w_op == 3'd3 && w_mis_w);
    assign w_ades  = (w_op == 3'd5 && w_mis_h) || (w_op == 3'd6 && w_mis_w);
`else
    assign w_adel = 1'b0;
    assign w_ades = 1'b0;
`endif
    assign w_exc   = EXE_ExcValid || Overflow_valid || w_adel || w_ades;
    assign w_code  = EXE_ExcValid ? EXE_ExcCode : Overflow_valid ? 5'h0C : w_adel ? 5'h04 : w_ades ? 5'h05 : 5'h00;
    // Only an address error owns the bad address; higher-priority causes leave it clear.
    assign w_badva = (!EXE_ExcValid && !Overflow_valid && (w_adel || w_ades)) ? EXE_ALUOut : 32'h0;

    always_ff @(posedge clk) begin
        if (rst || EXE_Flush || (!EXE_Stall && !EXE_Valid)) begin
            MEM_Valid     <= 1'b0;
            MEM_PC        <= 32'h0;
            MEM_ALUOut    <= 32'h0;
            MEM_MemOp     <= 3'd0;
            MEM_RegWr     <= 1'b0;
            MEM_Dst       <= 5'd0;
            MEM_StoreData <= 32'h0;
            MEM_ExcValid  <= 1'b0;
            MEM_ExcCode   <= 5'h0;
            MEM_BadVAddr  <= 32'h0;
        end else if (!EXE_Stall) begin
            MEM_Valid     <= 1'b1;
            MEM_PC        <= EXE_PC;
            MEM_ALUOut    <= EXE_ALUOut;
            MEM_MemOp     <= w_exc ? 3'd0 : w_op;
            MEM_RegWr     <= w_exc ? 1'b0 : EXE_RegWr;
            MEM_Dst       <= EXE_Dst;
            MEM_StoreData <= EXE_StoreData;
            MEM_ExcValid  <= w_exc;
            MEM_ExcCode   <= w_code;
            MEM_BadVAddr  <= w_badva;
        end
    end
endmodule

// File: tb/tb_exe_mem_reg.sv
// tb_exe_mem_reg: directed self-checking bench for exe_mem_reg.
// Expected alignment results follow MEM_ADDR_ALIGN_CHECK_EN when it is defined for the build.
module tb_exe_mem_reg;
    logic        clk = 1'b0;
    logic        rst, EXE_Stall, EXE_Flush, EXE_Valid, Overflow_valid, EXE_ExcValid, EXE_RegWr;
    logic [31:0] EXE_PC, EXE_ALUOut, EXE_StoreData;
    logic [4:0]  EXE_ExcCode, EXE_Dst;
    logic [2:0]  EXE_MemOp;
    logic        MEM_Valid, MEM_RegWr, MEM_ExcValid;
    logic [31:0] MEM_PC, MEM_ALUOut, MEM_StoreData, MEM_BadVAddr;
    logic [2:0]  MEM_MemOp;
    logic [4:0]  MEM_Dst, MEM_ExcCode;
    logic [143:0] obs, exp;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exe_mem_reg dut (
        .clk(clk), .rst(rst), .EXE_Stall(EXE_Stall), .EXE_Flush(EXE_Flush), .EXE_Valid(EXE_Valid),
        .EXE_PC(EXE_PC), .EXE_ALUOut(EXE_ALUOut), .Overflow_valid(Overflow_valid),
        .EXE_ExcValid(EXE_ExcValid), .EXE_ExcCode(EXE_ExcCode), .EXE_MemOp(EXE_MemOp),
        .EXE_RegWr(EXE_RegWr), .EXE_Dst(EXE_Dst), .EXE_StoreData(EXE_StoreData),
        .MEM_Valid(MEM_Valid), .MEM_PC(MEM_PC), .MEM_ALUOut(MEM_ALUOut), .MEM_MemOp(MEM_MemOp),
        .MEM_RegWr(MEM_RegWr), .MEM_Dst(MEM_Dst), .MEM_StoreData(MEM_StoreData),
        .MEM_ExcValid(MEM_ExcValid), .MEM_ExcCode(MEM_ExcCode), .MEM_BadVAddr(MEM_BadVAddr)
    );

    assign obs = {MEM_Valid, MEM_PC, MEM_ALUOut, MEM_MemOp, MEM_RegWr, MEM_Dst, MEM_StoreData,
                  MEM_ExcValid, MEM_ExcCode, MEM_BadVAddr};

    function automatic logic [143:0] pack(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                                          input logic [2:0] op, input logic rw, input logic [4:0] dst,
                                          input logic [31:0] sd, input logic ev, input logic [4:0] ec,
                                          input logic [31:0] bva);
        return {v, pc, alu, op, rw, dst, sd, ev, ec, bva};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] alu, input logic ovf,
                          input logic ev, input logic [4:0] ec, input logic [2:0] op, input logic rw,
                          input logic [4:0] dst, input logic [31:0] sd);
        EXE_Valid = v; EXE_PC = pc; EXE_ALUOut = alu; Overflow_valid = ovf; EXE_ExcValid = ev;
        EXE_ExcCode = ec; EXE_MemOp = op; EXE_RegWr = rw; EXE_Dst = dst; EXE_StoreData = sd;
    endtask

    task automatic test_reset();
        rst = 1; EXE_Stall = 0; EXE_Flush = 0;
        set_in(1, 32'h1111_1111, 32'h2222_2222, 0, 0, 0, 3'd3, 1, 5'd7, 32'h3333_3333);
        step();
        checks++;
        if (obs !== 144'h0) begin errors++; $display("FAIL reset got=%h exp=%h", obs, 144'h0); end
        rst = 0;
    endtask

    task automatic test_capture();
        set_in(1, 32'h0000_1000, 32'h1234_5678, 0, 0, 0, 3'd0, 1, 5'd3, 32'hDEAD_BEEF);
        step();
        exp = pack(1, 32'h0000_1000, 32'h1234_5678, 3'd0, 1, 5'd3, 32'hDEAD_BEEF, 0, 5'h0, 32'h0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL capture_alu got=%h exp=%h", obs, exp); end
        set_in(1, 32'h0000_1004, 32'h0000_0104, 0, 0, 0, 3'd6, 0, 5'd0, 32'hCAFE_F00D);
        step();
        exp = pack(1, 32'h0000_1004, 32'h0000_0104, 3'd6, 0, 5'd0, 32'hCAFE_F00D, 0, 5'h0, 32'h0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL capture_sw got=%h exp=%h", obs, exp); end
        set_in(1, 32'h0000_1008, 32'h0000_0200, 0, 0, 0, 3'd7, 1, 5'd9, 32'h0000_0055);
        step();
        exp = pack(1, 32'h0000_1008, 32'h0000_0200, 3'd0, 1, 5'd9, 32'h0000_0055, 0, 5'h0, 32'h0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL memop7 got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_exceptions();
        set_in(1, 32'h0000_2000, 32'h8000_0000, 1, 0, 0, 3'd0, 1, 5'd5, 32'h0000_0011);
        step();
        exp = pack(1, 32'h0000_2000, 32'h8000_0000, 3'd0, 0, 5'd5, 32'h0000_0011, 1, 5'h0C, 32'h0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL overflow got=%h exp=%h", obs, exp); end
        set_in(1, 32'h0000_2004, 32'h0000_0010, 1, 1, 5'h0A, 3'd6, 1, 5'd6, 32'h0000_0022);
        step();
        exp = pack(1, 32'h0000_2004, 32'h0000_0010, 3'd0, 0, 5'd6, 32'h0000_0022, 1, 5'h0A, 32'h0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL exc_priority got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_align();
        set_in(1, 32'h0000_3000, 32'h8000_0002, 0, 0, 0, 3'd3, 1, 5'd8, 32'h0000_0033);
        step();
`ifdef MEM_ADDR_ALIGN_CHECK_EN
        exp = pack(1, 32'h0000_3000, 32'h8000_0002, 3'd0, 0, 5'd8, 32'h0000_0033, 1, 5'h04, 32'h8000_0002);
`else
        exp = pack(1, 32'h0000_3000, 32'h8000_0002, 3'd3, 1, 5'd8, 32'h0000_0033, 0, 5'h0, 32'h0);
`endif
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL lw_misalign got=%h exp=%h", obs, exp); end
        set_in(1, 32'h0000_3004, 32'h0000_0041, 0, 0, 0, 3'd5, 0, 5'd0, 32'h0000_0044);
        step();
`ifdef MEM_ADDR_ALIGN_CHECK_EN
        exp = pack(1, 32'h0000_3004, 32'h0000_0041, 3'd0, 0, 5'd0, 32'h0000_0044, 1, 5'h05, 32'h0000_0041);
`else
        exp = pack(1, 32'h0000_3004, 32'h0000_0041, 3'd5, 0, 5'd0, 32'h0000_0044, 0, 5'h0, 32'h0);
`endif
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sh_misalign got=%h exp=%h", obs, exp); end
        set_in(1, 32'h0000_3008, 32'h0000_0042, 0, 0, 0, 3'd2, 1, 5'd4, 32'h0000_0000);
        step();
        exp = pack(1, 32'h0000_3008, 32'h0000_0042, 3'd2, 1, 5'd4, 32'h0, 0, 5'h0, 32'h0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL lh_aligned got=%h exp=%h", obs, exp); end
        set_in(1, 32'h0000_300C, 32'h0000_0041, 1, 0, 0, 3'd3, 1, 5'd4, 32'h0000_0000);
        step();
        exp = pack(1, 32'h0000_300C, 32'h0000_0041, 3'd0, 0, 5'd4, 32'h0, 1, 5'h0C, 32'h0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ovf_over_addr got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_stall_flush();
        set_in(1, 32'h0000_4000, 32'h0000_0ABC, 0, 0, 0, 3'd1, 1, 5'd12, 32'h1234_0000);
        step();
        exp = pack(1, 32'h0000_4000, 32'h0000_0ABC, 3'd1, 1, 5'd12, 32'h1234_0000, 0, 5'h0, 32'h0);
        EXE_Stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h0000_5000 + i, 32'h0000_0F00 + i, 1, 0, 0, 3'd6, 0, 5'd20, 32'h9999_0000 + i);
            step();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, exp); end
        end
        EXE_Flush = 1;
        step();
        checks++;
        if (obs !== 144'h0) begin errors++; $display("FAIL stall_flush got=%h exp=%h", obs, 144'h0); end
        EXE_Stall = 0; EXE_Flush = 0;
    endtask

    task automatic test_invalid();
        set_in(1, 32'h0000_6000, 32'h0000_0001, 0, 0, 0, 3'd0, 1, 5'd1, 32'h1);
        step();
        set_in(0, 32'h0000_6004, 32'h0000_0003, 1'bx, 0, 0, 3'd3, 1, 5'd2, 32'h2);
        step();
        checks++;
        if (MEM_ExcValid !== 1'b0 || MEM_Valid !== 1'b0) begin
            errors++; $display("FAIL invalid_slot got=%b%b exp=00", MEM_Valid, MEM_ExcValid);
        end
        checks++;
        if (obs !== 144'h0) begin errors++; $display("FAIL invalid_zero got=%h exp=%h", obs, 144'h0); end
    endtask

    task automatic test_reset_in_stall();
        set_in(1, 32'h0000_7000, 32'h0000_0777, 0, 0, 0, 3'd3, 1, 5'd31, 32'h7);
        step();
        EXE_Stall = 1; rst = 1;
        step();
        checks++;
        if (obs !== 144'h0) begin errors++; $display("FAIL reset_in_stall got=%h exp=%h", obs, 144'h0); end
        rst = 0;
        step();
        checks++;
        if (obs !== 144'h0) begin errors++; $display("FAIL stall_after_reset got=%h exp=%h", obs, 144'h0); end
        EXE_Stall = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'h0000_8000 + 4 * i, 32'h0000_0100 * i, 0, 0, 0, 3'(i), i[0], 5'(i + 1), 32'hA0 + i);
            step();
            exp = pack(1, 32'h0000_8000 + 4 * i, 32'h0000_0100 * i, 3'(i), i[0], 5'(i + 1), 32'hA0 + i, 0, 5'h0, 32'h0);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL b2b%0d got=%h exp=%h", i, obs, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_exceptions();
        test_align();
        test_stall_flush();
        test_invalid();
        test_reset_in_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exe_mem_reg.md
EXE_MEM_REG -- requirements
Module: exe_mem_reg

Interface
REQ-001 SHALL have clk  in  1  rising-edge clock; the block uses one clock only.
REQ-002 SHALL have rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have EXE_Stall  in  1  hold the current MEM-side contents.
REQ-004 SHALL have EXE_Flush  in  1  replace the next contents with a bubble.
REQ-005 SHALL have EXE_Valid  in  1  the EXE slot holds a real instruction.
REQ-006 SHALL have EXE_PC  in  32  instruction address.
REQ-007 SHALL have EXE_ALUOut  in  32  ALU result, also used as the memory address.
REQ-008 SHALL have Overflow_valid  in  1  ALU signed-overflow flag.
REQ-009 SHALL have EXE_ExcValid / EXE_ExcCode  in  1/5  exception already raised in IF/ID.
REQ-010 SHALL have EXE_MemOp  in  3  0 none, 1 LB, 2 LH, 3 LW, 4 SB, 5 SH, 6 SW, 7 reserved (treated as none).
REQ-011 SHALL have EXE_RegWr / EXE_Dst / EXE_StoreData  in  1/5/32  register-write enable, destination, store data.
REQ-012 SHALL have MEM_Valid, MEM_PC, MEM_ALUOut, MEM_MemOp, MEM_RegWr, MEM_Dst, MEM_StoreData  out  same widths  registered copies.
REQ-013 SHALL have MEM_ExcValid / MEM_ExcCode / MEM_BadVAddr  out  1/5/32  merged exception for this slot.

Function
REQ-014 SHALL capture all inputs at a clk edge where rst=0, EXE_Flush=0 and EXE_Stall=0; latency is exactly 1 cycle.
REQ-015 SHALL keep every output unchanged when EXE_Stall=1 and EXE_Flush=0.
REQ-016 SHALL load the reset values (REQ-024) when EXE_Flush=1, regardless of EXE_Stall, because flush has priority over stall.
REQ-017 SHALL, on capture with EXE_Valid=0, load the reset values, so that invalid slots never carry exceptions.
REQ-018 SHALL select the exception by priority, highest first: EXE_ExcValid (pass EXE_ExcCode) > Overflow_valid (code 0x0C) > address error (REQ-027).
REQ-019 SHALL set MEM_BadVAddr to EXE_ALUOut only for an address error; otherwise it SHALL be 0.
REQ-020 SHALL, when MEM_ExcValid=1 is loaded, force MEM_RegWr=0 and MEM_MemOp=0, so that no architectural side effect occurs.
REQ-021 SHALL, when MEM_ExcValid is loaded with a value of 0, pass MEM_RegWr, MEM_MemOp, MEM_Dst and MEM_StoreData through unmodified; MemOp 7 SHALL be stored as 0.
REQ-022 SHALL always pass MEM_PC and MEM_ALUOut through on capture, including for exception slots.
REQ-023 SHALL treat an X on Overflow_valid as 0 when EXE_Valid=0, as a consequence of REQ-017.

Reset
REQ-024 SHALL, at a clk edge with rst=1, set every output to 0, including MEM_PC=32'h0 and MEM_ExcCode=5'h0.
REQ-025 SHALL give rst priority over EXE_Flush and EXE_Stall; a reset in the middle of a stall SHALL discard the held contents.

Configuration
REQ-026 SHALL compile the address-alignment check only when macro MEM_ADDR_ALIGN_CHECK_EN is defined.
REQ-027 SHALL, with the macro defined, flag the following as an address error: LH/LW with EXE_ALUOut[0]!=0, and LW with EXE_ALUOut[1:0]!=0, using code 0x04 (AdEL); SH/SW under the same misalignment rules SHALL use code 0x05 (AdES).
REQ-028 SHALL, without the macro, raise no address errors, tie MEM_BadVAddr to 0, and pass the MemOp of misaligned accesses through.

Verification
REQ-029 SHALL cover: rst=1 for one edge while MEM_Valid=1 and EXE_Stall=1 -> all outputs 0 on the next cycle.
REQ-030 SHALL cover: ADD with Overflow_valid=1, EXE_Valid=1, EXE_RegWr=1, Dst=5 -> MEM_ExcValid=1, MEM_ExcCode=0x0C, MEM_RegWr=0.
REQ-031 SHALL cover: EXE_ExcValid=1 with code 0x0A together with Overflow_valid=1 -> MEM_ExcCode=0x0A.
REQ-032 SHALL cover: LW at EXE_ALUOut=32'h8000_0002 with the macro defined -> MEM_ExcCode=0x04, MEM_BadVAddr=32'h8000_0002, MEM_MemOp=0; without the macro -> MEM_ExcValid=0, MEM_MemOp=3.
REQ-033 SHALL cover: EXE_Stall=1 held for 3 cycles while inputs change -> outputs hold their first captured values; EXE_Stall=1 with EXE_Flush=1 -> bubble loaded.
REQ-034 SHALL cover: EXE_Valid=0 with Overflow_valid=X -> MEM_ExcValid=0 and MEM_Valid=0.
